// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave that deserialises 10-bit command frames for the RAM and
// serialises the RAM's read byte back on MISO, one bit per clk edge.
module spi_slave_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);
  localparam int FW = DATA_WIDTH + 2;
  localparam int CW = $clog2(TX_TIMEOUT > FW ? TX_TIMEOUT : FW);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_SS, REPLY_WAIT, REPLY_TX} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [FW-2:0]         r_shift;
  logic [FW-1:0]         w_frame, r_rx_data;
  logic [DATA_WIDTH-1:0] r_tx;
  logic                  r_rd_addr_seen, r_miso, r_rx_valid, w_shifting, w_done, w_miso;

  assign w_frame    = {r_shift, MOSI};
  assign w_shifting = r_state inside {WRITE, READ_ADD, READ_DATA};
  assign w_done     = w_shifting && !SS_n && r_cnt == FRAME_LAST;

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    if (SS_n) begin
      w_next = IDLE;
      w_cnt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_next = CHK_CMD;
          w_cnt  = '0;
        end
        CHK_CMD: begin
          w_next = !MOSI ? WRITE : r_rd_addr_seen ? READ_DATA : READ_ADD;
          w_cnt  = CW'(1);
        end
        WRITE, READ_ADD, READ_DATA: begin
          w_cnt = w_done ? '0 : r_cnt + 1'b1;
          if (w_done)
            w_next = (r_state == READ_DATA && w_frame[FW-1:FW-2] == 2'b11) ? REPLY_WAIT : WAIT_SS;
        end
        // tx_valid during the rx_valid cycle is a stale level from an earlier read
        REPLY_WAIT: if (!r_rx_valid) begin
          w_next = tx_valid ? REPLY_TX : r_cnt == TO_LAST ? WAIT_SS : REPLY_WAIT;
          w_cnt  = (tx_valid || r_cnt == TO_LAST) ? '0 : r_cnt + 1'b1;
        end
        REPLY_TX: begin
          w_next = r_cnt == BYTE_LAST ? WAIT_SS : REPLY_TX;
          w_cnt  = r_cnt == BYTE_LAST ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
    w_miso = w_next == REPLY_TX && (r_state == REPLY_TX ? r_tx[DATA_WIDTH-1] : tx_data[DATA_WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_tx           <= '0;
      r_rd_addr_seen <= 1'b0;
      r_miso         <= 1'b0;
      r_rx_valid     <= 1'b0;
      r_rx_data      <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      r_miso     <= w_miso;
      r_rx_valid <= w_done;
      if (r_state == CHK_CMD || w_shifting) r_shift <= w_frame[FW-2:0];
      if (w_done) begin
        r_rx_data <= w_frame;
        if (w_frame[FW-1]) r_rd_addr_seen <= !w_frame[FW-2];
      end
      if (w_next == REPLY_TX) r_tx <= r_state == REPLY_TX ? r_tx << 1 : tx_data << 1;
    end
  end

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: scoreboard bench; stimulus queues expected frames/replies, a
// negedge monitor pops them on rx_valid and checks MISO every cycle.
module tb_spi_slave_if;
  logic       clk = 1'b0, rst = 1'b1, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic [9:0] rx_data;
  logic       rx_valid, MISO;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(8), .TX_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  typedef struct {logic [9:0] f; int n; int start; logic [7:0] b;} exp_t;
  exp_t       q[$];
  exp_t       cur = '{f: 10'h0, n: 0, start: 0, b: 8'h0};
  int         checks = 0, errors = 0, since = 1000, ram_delay = 1, pend = 0;
  bit         armed = 1'b0, rd_seen = 1'b0, ram_clr = 1'b0, ram_pre = 1'b0;
  logic [7:0] ram_byte = '0, pre_byte = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // RAM stand-in: answers a 11 frame ram_delay cycles after rx_valid, else holds its level
  always @(posedge clk) begin
    if (ram_clr) tx_valid <= 1'b0;
    if (ram_pre) begin
      tx_valid <= 1'b1;
      tx_data  <= pre_byte;
    end
    if (rx_valid && rx_data[9:8] == 2'b11) pend <= ram_delay;
    else if (pend != 0) pend <= pend - 1;
    if ((rx_valid && rx_data[9:8] == 2'b11) ? ram_delay == 1 : pend == 2) begin
      tx_valid <= 1'b1;
      tx_data  <= ram_byte;
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      if (rx_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_valid: unexpected pulse rx_data=%0h at %0t", rx_data, $time);
          cur.n = 0;
        end else begin
          cur = q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(cur.f));
        end
        since = 0;
      end else if (since < 1000) since++;
      chk("miso", 32'(MISO),
          32'((since >= cur.start && since - cur.start < cur.n) ? cur.b[7-(since-cur.start)] : 1'b0));
    end
  end

  task automatic frame(input logic [9:0] f, input int nb, input int h);
    exp_t e;
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      MOSI = f[9-i];
    end
    if (nb == 10) begin
      e.f     = f;
      e.b     = ram_byte;
      e.start = ram_delay + 1;
      e.n     = (f[9:8] == 2'b11 && rd_seen && ram_delay <= 16) ? h - e.start + 1 : 0;
      e.n     = e.n < 0 ? 0 : e.n > 8 ? 8 : e.n;
      if (f[9:8] == 2'b10) rd_seen = 1'b1;
      else if (f[9:8] == 2'b11) rd_seen = 1'b0;
      q.push_back(e);
    end
    repeat (nb == 10 ? h : 0) begin
      @(negedge clk);
      MOSI = 1'($urandom);
    end
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ram_clr = 1'b1;
    @(negedge clk);
    ram_clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_miso", 32'(MISO), 0);
    rst   = 1'b0;
    armed = 1'b1;
    frame(10'h005, 10, 2);
    frame(10'h1A5, 10, 3);
    frame(10'h006, 10, 1);
    frame(10'h205, 10, 2);
    ram_byte = 8'hA5;
    frame(10'h300, 10, 12);
    @(negedge clk);
    pre_byte = 8'h3C;
    ram_pre  = 1'b1;
    @(negedge clk);
    ram_pre = 1'b0;
    frame(10'h2AA, 10, 1);
    ram_byte = 8'hC3;
    frame(10'h3FF, 10, 12);
    frame(10'h1C0, 6, 0);
    frame(10'h001, 10, 2);
    frame(10'h2F0, 10, 1);
    ram_byte = 8'h96;
    frame(10'h3AB, 10, 5);
    frame(10'h211, 10, 1);
    pulse_clr();
    ram_delay = 17;
    ram_byte  = 8'hFF;
    frame(10'h322, 10, 30);
    frame(10'h233, 10, 1);
    pulse_clr();
    ram_delay = 16;
    ram_byte  = 8'h81;
    frame(10'h344, 10, 30);
    ram_delay = 1;
    frame(10'h2AB, 10, 1);
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      MOSI = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rx_valid", 32'(rx_valid), 0);
    chk("midrst_rx_data", 32'(rx_data), 0);
    chk("midrst_miso", 32'(MISO), 0);
    rst     = 1'b0;
    SS_n    = 1'b1;
    rd_seen = 1'b0;
    @(negedge clk);
    ram_byte = 8'h5A;
    frame(10'h3C5, 10, 12);
    repeat (40) begin
      ram_byte = 8'($urandom);
      frame(10'($urandom), $urandom_range(0, 3) == 0 ? $urandom_range(1, 9) : 10, $urandom_range(0, 12));
    end
    repeat (5) @(negedge clk);
    chk("pending_frames", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end of the SPI-to-RAM subsystem.
- Deserialises 10-bit command frames from an external SPI master (MOSI, SS_n) and presents them to the single-port RAM as a one-cycle rx_valid strobe with rx_data[9:0].
- On read-data frames, waits for the RAM's tx_valid/tx_data response and serialises the byte back on MISO, MSB first.
- The system clock is the SPI bit clock: one bit per clk rising edge.

Parameters:
- DATA_WIDTH, 8: RAM word and address width. Frame width is DATA_WIDTH+2.
- TX_TIMEOUT, 16: maximum cycles to wait for tx_valid after a read-data frame before abandoning the reply.

Ports:
- clk  input  1  system/SPI bit clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  slave select, active low; high aborts or ends a transaction.
- MOSI  input  1  serial data in, MSB first, sampled on clk rising edge.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  DATA_WIDTH+2  assembled frame to RAM; [9:8] command, [7:0] payload.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  DATA_WIDTH  read byte from RAM.
- tx_valid  input  1  RAM read-data valid; level, may be stale-high.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, MISO=0, rx_valid=0, rx_data=0, bit counter=0, rd_addr_seen=0. Reset overrides everything, including mid-frame or mid-reply.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_SS.
- IDLE:
  - SS_n=0 -> CHK_CMD; otherwise stay.
  - No bits are captured in IDLE; the first frame bit is presented the cycle after SS_n falls.
- CHK_CMD:
  - Capture MOSI as frame bit 9.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in the remaining 9 bits, MSB first. Frame complete on the 10th captured bit in total.
- Frame complete:
  - rx_data is registered with the full frame.
  - rx_valid=1 for exactly the following cycle; rx_data holds its value until the next frame.
  - rd_addr_seen is set if the frame's [9:8]=10 and cleared if [9:8]=11. Other codes leave it unchanged. rx_data is forwarded as received regardless of state.
- After a WRITE or READ_ADD frame, or a READ_DATA frame whose [9:8]!=11: go to WAIT_SS.
- READ_DATA with frame[9:8]=11: reply phase.
  - Ignore tx_valid in the rx_valid cycle itself, to reject a stale level.
  - Starting the cycle after the rx_valid pulse, the first cycle with tx_valid=1 latches tx_data.
  - MISO then drives bits 7..0 on the next 8 consecutive cycles; latency from rx_valid to MISO bit 7 is 2 cycles with the standard 1-cycle RAM.
  - After bit 0: MISO=0, go to WAIT_SS.
  - If TX_TIMEOUT cycles elapse without tx_valid: no reply, MISO stays 0, go to WAIT_SS.
- WAIT_SS: ignore MOSI; stay until SS_n=1, then IDLE. Consecutive frames therefore need at least one SS_n-high cycle between them.
- SS_n=1 in any non-IDLE state:
  - Next state is IDLE; bit counter and reply counter cleared; MISO=0.
  - A partial frame is discarded: no rx_valid, rx_data unchanged, rd_addr_seen unchanged.
- MISO is 0 whenever no reply bit is being driven.
- MOSI activity while SS_n=1 has no effect.

Test Plan:
- Reset, then write address:
  - Stimulus: rst high for 2 cycles, then SS_n low and shift 00_0000_0101.
  - Required: exactly one rx_valid pulse with rx_data=10'h005, MISO=0 throughout, state WAIT_SS until SS_n high.
- Write data:
  - Stimulus: frame 01_1010_0101.
  - Required: rx_data=10'h1A5 with a single rx_valid pulse.
  - Required: a following frame 00_0000_0110 after an SS_n-high gap gives rx_data=10'h006.
- Read sequence:
  - Stimulus: frame 10_0000_0101, SS_n high, then frame 11_0000_0000; the RAM model returns tx_valid=1, tx_data=8'hA5 one cycle after rx_valid.
  - Required: MISO=1,0,1,0,0,1,0,1 starting 2 cycles after rx_valid; rd_addr_seen 1 then 0.
- Stale tx_valid:
  - Stimulus: hold tx_valid=1 with tx_data=8'h3C before the 11 frame; the model updates to 8'hC3 one cycle after rx_valid.
  - Required: serialised byte is 8'hC3, not 8'h3C.
- Abort:
  - SS_n high after 6 bits of frame 01_xxxx -> no rx_valid, next full frame 00_0000_0001 decoded correctly.
  - SS_n high mid-reply -> MISO=0 on the next cycle.
- Timeout and reset mid-operation:
  - Stimulus: frame 11_... with tx_valid held 0.
  - Required: MISO stays 0, state WAIT_SS after 16 cycles.
  - Stimulus: rst asserted mid-frame.
  - Required: all outputs 0 the next cycle; rd_addr_seen=0 and the next 1-prefixed frame enters READ_ADD.
